mem_read_return: RTL and testbench
==================================

MEM_READ_RETURN -- requirements
Module: mem_read_return

Interface
REQ-001 Parameter DW, default 16: read-data width in bits.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles before a bus error is returned.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  CPU read request present.
REQ-006 req_sel  input  2  target region: 0 instruction, 1 mmr, 2 stack, 3 unmapped.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 instr_rdata, mmr_rdata, stack_rdata  input  DW each  region read data.
REQ-009 instr_rvalid, mmr_rvalid, stack_rvalid  input  1 each  region data-valid strobes.
REQ-010 rdata  output  DW  data returned to the CPU.
REQ-011 rvalid  output  1  one-cycle response strobe.
REQ-012 err  output  1  error response; qualified by rvalid.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-015 On acceptance the block SHALL latch req_sel and clear the timeout counter. It goes to WAIT for sel 0-2 and to RESP with err=1 for sel 3.
REQ-016 In WAIT, only the rvalid of the latched region SHALL be honoured; strobes from other regions are ignored.
REQ-017 A region rvalid asserted in the same cycle as acceptance SHALL be ignored; data must arrive no earlier than the first WAIT cycle.
REQ-018 On the latched region's rvalid in WAIT, the block SHALL register that region's rdata, set err=0 and go to RESP. The response appears exactly 1 cycle after the source strobe.
REQ-019 The timeout counter SHALL increment on every WAIT cycle without a valid strobe.
REQ-020 When the counter reaches TIMEOUT, the block SHALL go to RESP with err=1 and rdata=0.
REQ-021 If the valid strobe and the timeout occur in the same cycle, the data SHALL win and err=0.
REQ-022 RESP SHALL last exactly one cycle with rvalid=1, then return to IDLE.
REQ-023 The earliest next acceptance SHALL be the cycle after RESP, so back-to-back throughput is one request per 3 cycles minimum.
REQ-024 Outside RESP, rvalid and err SHALL be 0 and rdata SHALL be 0; rdata is never a stale value.
REQ-025 The counter SHALL saturate and never wrap.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, latched sel=0, counter=0, rdata=0, rvalid=0 and err=0.
REQ-027 req_ready SHALL be 1 on the first cycle after reset release.
REQ-028 A reset during WAIT or RESP SHALL abort the transaction with no response.
REQ-029 A source strobe arriving after that reset SHALL be ignored.

Structure
REQ-030 The shared package cpu_pkg SHALL hold the region select enum (SEL_INSTR=0, SEL_MMR=1, SEL_STACK=2, SEL_NONE=3), the state typedef, and the DW and TIMEOUT defaults.
REQ-031 The timeout counter SHALL be the single sub-module mem_timeout_ctr, with ports clear, enable and expired.
REQ-032 All outputs SHALL be registered, and every combinational next-state block SHALL assign every signal on every path.

Verification
REQ-033 Reset: hold rst_n=0 for 2 cycles -> rdata=0, rvalid=0, err=0; req_ready=1 after release.
REQ-034 MMR read: sel=1 accepted; mmr_rvalid with 0xBEEF 3 cycles later -> rvalid=1, rdata=0xBEEF, err=0 on the next cycle, and for that one cycle only.
REQ-035 Wrong-region strobe: sel=2 pending; instr_rvalid with 0x1234 -> no response. stack_rvalid with 0x00A5 -> rdata=0x00A5.
REQ-036 Unmapped: sel=3 accepted -> rvalid=1, err=1, rdata=0 one cycle later, with no wait.
REQ-037 Timeout: sel=0 with no strobe -> err=1 after 15 WAIT cycles. Separately, a strobe on the 15th WAIT cycle -> data returned with err=0.
REQ-038 Reset mid-WAIT: sel=1 accepted, rst_n=0 for 1 cycle, then mmr_rvalid -> no rvalid, and req_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared region select, state and sizing definitions for the CPU read path
`timescale 1ns/1ps
package cpu_pkg;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        SEL_INSTR = 2'd0,
        SEL_MMR   = 2'd1,
        SEL_STACK = 2'd2,
        SEL_NONE  = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating wait-cycle counter that flags the last permitted WAIT cycle
`timescale 1ns/1ps
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // High on the WAIT cycle whose increment would bring the count up to TIMEOUT.
    assign expired = ((int'(cnt) + 1) >= TIMEOUT);
endmodule

// File: rtl/mem_read_return.sv
// rtl/mem_read_return.sv - routes one CPU read to a region and returns its data, a timeout or an unmapped error
`timescale 1ns/1ps
module mem_read_return
    import cpu_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic [1:0]    req_sel,
    output logic          req_ready,
    input  logic [DW-1:0] instr_rdata,
    input  logic [DW-1:0] mmr_rdata,
    input  logic [DW-1:0] stack_rdata,
    input  logic          instr_rvalid,
    input  logic          mmr_rvalid,
    input  logic          stack_rvalid,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          err
);
    state_e        state, state_n;
    sel_e          sel_q, sel_n;
    logic [DW-1:0] rdata_n;
    logic          rvalid_n, err_n;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic          ctr_clear, ctr_enable, ctr_expired;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (ctr_expired)
    );

    // Only the region latched at acceptance can complete the transaction.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        case (sel_q)
            SEL_INSTR: begin hit = instr_rvalid; hit_data = instr_rdata; end
            SEL_MMR:   begin hit = mmr_rvalid;   hit_data = mmr_rdata;   end
            SEL_STACK: begin hit = stack_rvalid; hit_data = stack_rdata; end
            SEL_NONE:  begin hit = 1'b0;         hit_data = '0;          end
        endcase
    end

    always_comb begin
        state_n    = state;
        sel_n      = sel_q;
        rdata_n    = '0;
        rvalid_n   = 1'b0;
        err_n      = 1'b0;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    sel_n     = sel_e'(req_sel);
                    ctr_clear = 1'b1;
                    if (sel_e'(req_sel) == SEL_NONE) begin
                        state_n  = ST_RESP;
                        rvalid_n = 1'b1;
                        err_n    = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Data takes priority over a timeout landing in the same cycle.
                if (hit) begin
                    state_n  = ST_RESP;
                    rvalid_n = 1'b1;
                    rdata_n  = hit_data;
                end else begin
                    ctr_enable = 1'b1;
                    if (ctr_expired) begin
                        state_n  = ST_RESP;
                        rvalid_n = 1'b1;
                        err_n    = 1'b1;
                    end
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= SEL_INSTR;
            rdata     <= '0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            sel_q     <= sel_n;
            rdata     <= rdata_n;
            rvalid    <= rvalid_n;
            err       <= err_n;
            req_ready <= (state_n == ST_IDLE);
        end
    end
endmodule

// File: tb/tb_mem_read_return.sv
// tb/tb_mem_read_return.sv - randomized scoreboard bench for mem_read_return
`timescale 1ns/1ps
module tb_mem_read_return;
    import cpu_pkg::*;

    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [1:0]    req_sel = 2'd0;
    logic          req_ready;
    logic [DW-1:0] instr_rdata = '0, mmr_rdata = '0, stack_rdata = '0;
    logic          instr_rvalid = 1'b0, mmr_rvalid = 1'b0, stack_rvalid = 1'b0;
    logic [DW-1:0] rdata;
    logic          rvalid, err;

    mem_read_return #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_sel      (req_sel),
        .req_ready    (req_ready),
        .instr_rdata  (instr_rdata),
        .mmr_rdata    (mmr_rdata),
        .stack_rdata  (stack_rdata),
        .instr_rvalid (instr_rvalid),
        .mmr_rvalid   (mmr_rvalid),
        .stack_rvalid (stack_rvalid),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            when;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", 32'(rvalid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_cycle", cyc, e.when);
                    check("rdata", 32'(rdata), 32'(e.data));
                    check("err", 32'(err), 32'(e.err));
                end
            end else begin
                check("idle_rdata", 32'(rdata), 32'd0);
                check("idle_err", 32'(err), 32'd0);
            end
        end
    end

    task automatic clear_strobes();
        instr_rvalid = 1'b0;
        mmr_rvalid   = 1'b0;
        stack_rvalid = 1'b0;
    endtask

    task automatic drive(input logic [1:0] s, input logic [DW-1:0] v);
        case (s)
            2'd0: begin instr_rvalid = 1'b1; instr_rdata = v; end
            2'd1: begin mmr_rvalid   = 1'b1; mmr_rdata   = v; end
            2'd2: begin stack_rvalid = 1'b1; stack_rdata = v; end
            default: ;
        endcase
    endtask

    // d: WAIT cycle (1-based) carrying the right strobe; outside 1..TO means none.
    // wk/wsel: WAIT cycle and region of a stray strobe; early: strobe in the accept cycle.
    task automatic do_read(input logic [1:0] sel, input int d, input logic [DW-1:0] data,
                           input int wk, input logic [1:0] wsel, input bit early);
        int   acc;
        int   last;
        int   tries;
        exp_t e;
        tries = 0;
        @(negedge clk);
        while (!req_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = sel;
        if (early) drive(sel, 16'hDEAD);
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        req_sel   = 2'($urandom_range(0, 3));
        clear_strobes();
        if (sel == 2'd3) begin
            e.when = acc;      e.data = '0;   e.err = 1'b1; last = 0;
        end else if (d >= 1 && d <= TO) begin
            e.when = acc + d;  e.data = data; e.err = 1'b0; last = d;
        end else begin
            e.when = acc + TO; e.data = '0;   e.err = 1'b1; last = TO;
        end
        sb.push_back(e);
        check("busy_ready", 32'(req_ready), 32'd0);
        for (int k = 1; k <= last; k++) begin
            instr_rdata = 16'($urandom);
            mmr_rdata   = 16'($urandom);
            stack_rdata = 16'($urandom);
            clear_strobes();
            if (k == wk && wsel != sel) drive(wsel, 16'h1234);
            if (k == d) drive(sel, data);
            @(posedge clk);
            #1;
        end
        clear_strobes();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [1:0] s;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        do_read(2'd1, 3, 16'hBEEF, 0, 2'd0, 1'b0);
        do_read(2'd2, 5, 16'h00A5, 2, 2'd0, 1'b0);
        do_read(2'd3, 0, 16'h0000, 0, 2'd0, 1'b0);
        do_read(2'd0, 99, 16'h0000, 3, 2'd1, 1'b0);
        do_read(2'd0, TO, 16'h5A5A, 0, 2'd0, 1'b0);
        do_read(2'd2, 1, 16'hC0DE, 0, 2'd0, 1'b1);
        do_read(2'd1, 4, 16'h4242, 4, 2'd2, 1'b0);

        // Reset in the middle of WAIT, then a late strobe from the aborted region.
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 2'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'd1, 16'h7777);
        @(posedge clk);
        #1;
        clear_strobes();
        @(negedge clk);
        check("abort_rvalid", 32'(rvalid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            s = 2'($urandom_range(0, 3));
            do_read(s, int'($urandom_range(1, 18)), 16'($urandom), int'($urandom_range(0, 6)),
                    s + 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
